// File: rtl/mips_md_pkg.sv
// mips_md_pkg: shared types for the multiply/divide unit.
//   md_op_t    - 4-bit MD operation code carried down the EX stage
//   md_state_t - iteration FSM states
//   md_cnt_w   - width of the iteration counter for a given XLEN
package mips_md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_t;

  // Counter must be able to hold XLEN itself.
  function automatic int md_cnt_w(input int xlen);
    return $clog2(xlen) + 1;
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// md_iter_core: shared shift/add-subtract datapath, one step per cycle.
//   clk, nrst    - clock, async active-low reset
//   start_i      - load operands (a_i -> LO half / dividend, b_i -> multiplicand / divisor)
//   step_i       - perform one iteration
//   div_mode_i   - 1: restoring divide step, 0: shift-add multiply step
//   a_i, b_i     - unsigned operand magnitudes
//   hi_o, lo_o   - accumulator halves: product HI:LO, or remainder:quotient
module md_iter_core import mips_md_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            start_i,
  input  logic            step_i,
  input  logic            div_mode_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN-1:0] acc_hi_q, acc_hi_d;
  logic [XLEN-1:0] acc_lo_q, acc_lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN:0]   sum_s;
  logic [XLEN:0]   shifted_s;
  logic [XLEN:0]   diff_s;

  // Next accumulator value: load, one mul/div step, or hold.
  always_comb begin
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    // Multiply: conditionally add multiplicand to HI, then shift the carry:HI:LO right.
    sum_s     = acc_lo_q[0] ? ({1'b0, acc_hi_q} + {1'b0, opnd_q}) : {1'b0, acc_hi_q};
    // Divide: bring the next dividend bit into the partial remainder and trial-subtract.
    shifted_s = {acc_hi_q, acc_lo_q[XLEN-1]};
    diff_s    = shifted_s - {1'b0, opnd_q};
    if (start_i) begin
      acc_hi_d = '0;
      acc_lo_d = a_i;
      opnd_d   = b_i;
    end else if (step_i) begin
      if (div_mode_i) begin
        if (!diff_s[XLEN]) begin
          acc_hi_d = diff_s[XLEN-1:0];
          acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b1};
        end else begin
          acc_hi_d = shifted_s[XLEN-1:0];
          acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        acc_hi_d = sum_s[XLEN:1];
        acc_lo_d = {sum_s[0], acc_lo_q[XLEN-1:1]};
      end
    end else begin
      acc_hi_d = acc_hi_q;
    end
  end

  // Accumulator and operand registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
    end else begin
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
    end
  end

  assign hi_o = acc_hi_q;
  assign lo_o = acc_lo_q;

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle multiply/divide unit with HI/LO registers (EX stage).
//   clk, nrst          - pipeline clock, async active-low reset
//   i_EX_ctrl_MDOp     - md_op_t operation code
//   i_EX_ctrl_Flush    - EX instruction squashed; suppresses issue and stall
//   i_EX_data_RSData   - rs operand
//   i_EX_data_RTData   - rt operand
//   o_MEM_data_MDOut   - HI for MFHI, LO for MFLO, otherwise 0
//   o_HZ_ctrl_Stall    - MD instruction must wait for the in-flight op
//   o_MD_busy          - iteration (or fix-up) in progress
// Build option: MULDIV_FAST_MUL_EN selects a single-cycle combinational multiplier.
module ex_muldiv import mips_md_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [3:0]      i_EX_ctrl_MDOp,
  input  logic            i_EX_ctrl_Flush,
  input  logic [XLEN-1:0] i_EX_data_RSData,
  input  logic [XLEN-1:0] i_EX_data_RTData,
  output logic [XLEN-1:0] o_MEM_data_MDOut,
  output logic            o_HZ_ctrl_Stall,
  output logic            o_MD_busy
);

  localparam int             CW       = md_cnt_w(XLEN);
  localparam logic [CW-1:0]  CNT_LAST = CW'(XLEN - 1);

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  md_op_t          op_s;
  md_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic            neg_res_q, neg_rem_q, div_zero_q, op_div_q;
  logic            md_req_s, busy_s, issue_s;
  logic            is_mul_s, is_div_s, is_signed_s, core_start_s;
  logic            rs_neg_s, rt_neg_s;
  logic [XLEN-1:0] rs_mag_s, rt_mag_s;
  logic [XLEN-1:0] core_hi_s, core_lo_s;
  logic [2*XLEN-1:0] prod_fix_s, fast_prod_s;
  logic [XLEN-1:0] quo_fix_s, rem_fix_s;

  assign op_s     = md_op_t'(i_EX_ctrl_MDOp);
  // Undefined codes are treated like NONE so they neither stall nor issue.
  assign md_req_s = (i_EX_ctrl_MDOp != 4'd0) && (i_EX_ctrl_MDOp <= 4'd8);
  assign busy_s   = (state_q != ST_IDLE);
  assign o_HZ_ctrl_Stall = busy_s && md_req_s && !i_EX_ctrl_Flush;
  assign o_MD_busy       = busy_s;
  assign issue_s  = md_req_s && !i_EX_ctrl_Flush && !o_HZ_ctrl_Stall;

  assign is_mul_s     = (op_s == MD_MULT) || (op_s == MD_MULTU);
  assign is_div_s     = (op_s == MD_DIV)  || (op_s == MD_DIVU);
  assign is_signed_s  = (op_s == MD_MULT) || (op_s == MD_DIV);
  assign rs_neg_s     = is_signed_s && i_EX_data_RSData[XLEN-1];
  assign rt_neg_s     = is_signed_s && i_EX_data_RTData[XLEN-1];
  assign rs_mag_s     = rs_neg_s ? -i_EX_data_RSData : i_EX_data_RSData;
  assign rt_mag_s     = rt_neg_s ? -i_EX_data_RTData : i_EX_data_RTData;
  assign core_start_s = issue_s && ((is_mul_s && !FAST_MUL) || is_div_s);

`ifdef MULDIV_FAST_MUL_EN
  // Sign-extend to 2*XLEN; the truncated product is correct for both signednesses.
  assign fast_prod_s = {{XLEN{rs_neg_s}}, i_EX_data_RSData} *
                       {{XLEN{rt_neg_s}}, i_EX_data_RTData};
`else
  assign fast_prod_s = '0;
`endif

  md_iter_core #(.XLEN(XLEN)) u_core (
    .clk        (clk),
    .nrst       (nrst),
    .start_i    (core_start_s),
    .step_i     ((state_q == ST_MUL) || (state_q == ST_DIV)),
    .div_mode_i (state_q == ST_DIV),
    .a_i        (rs_mag_s),
    .b_i        (rt_mag_s),
    .hi_o       (core_hi_s),
    .lo_o       (core_lo_s)
  );

  // Sign fix-up of the unsigned core result.
  assign prod_fix_s = neg_res_q ? -{core_hi_s, core_lo_s} : {core_hi_s, core_lo_s};
  assign quo_fix_s  = div_zero_q ? {XLEN{1'b1}} : (neg_res_q ? -core_lo_s : core_lo_s);
  assign rem_fix_s  = neg_rem_q ? -core_hi_s : core_hi_s;

  // FSM next state and iteration counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (core_start_s) begin
          state_d = is_div_s ? ST_DIV : ST_MUL;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      ST_FIX:  state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // HI/LO next value: fix-up result, move-to, or fast product.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == ST_FIX) begin
      if (op_div_q) begin
        hi_d = rem_fix_s;
        lo_d = quo_fix_s;
      end else begin
        hi_d = prod_fix_s[2*XLEN-1:XLEN];
        lo_d = prod_fix_s[XLEN-1:0];
      end
    end else if (issue_s) begin
      case (op_s)
        MD_MTHI: hi_d = i_EX_data_RSData;
        MD_MTLO: lo_d = i_EX_data_RSData;
        MD_MULT, MD_MULTU: begin
          if (FAST_MUL) begin
            hi_d = fast_prod_s[2*XLEN-1:XLEN];
            lo_d = fast_prod_s[XLEN-1:0];
          end else begin
            hi_d = hi_q;
          end
        end
        default: lo_d = lo_q;
      endcase
    end else begin
      hi_d = hi_q;
    end
  end

  // HI/LO read port.
  always_comb begin
    o_MEM_data_MDOut = '0;
    case (op_s)
      MD_MFHI: o_MEM_data_MDOut = hi_q;
      MD_MFLO: o_MEM_data_MDOut = lo_q;
      default: o_MEM_data_MDOut = '0;
    endcase
  end

  // FSM state, counter and architectural HI/LO.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Sign and special-case flags captured when an iterative op starts.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      op_div_q   <= 1'b0;
    end else if (core_start_s) begin
      neg_res_q  <= rs_neg_s ^ rt_neg_s;
      neg_rem_q  <= rs_neg_s;
      div_zero_q <= is_div_s && (i_EX_data_RTData == '0);
      op_div_q   <= is_div_s;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv at XLEN=32.
module tb_ex_muldiv;
  import mips_md_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int          MUL_STALL = 0;
  localparam logic [31:0] MUL_BUSY  = 32'd0;
`else
  localparam int          MUL_STALL = 33;
  localparam logic [31:0] MUL_BUSY  = 32'd1;
`endif

  logic        clk = 1'b0;
  logic        nrst;
  logic [3:0]  mdop;
  logic        flush;
  logic [31:0] rsd, rtd;
  logic [31:0] mdout;
  logic        stall, busy;
  int          checks = 0;
  int          errors = 0;
  int          n;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32)) dut (
    .clk              (clk),
    .nrst             (nrst),
    .i_EX_ctrl_MDOp   (mdop),
    .i_EX_ctrl_Flush  (flush),
    .i_EX_data_RSData (rsd),
    .i_EX_data_RTData (rtd),
    .o_MEM_data_MDOut (mdout),
    .o_HZ_ctrl_Stall  (stall),
    .o_MD_busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input md_op_t op, input logic fl, input logic [31:0] rs, input logic [31:0] rt);
    mdop  = op;
    flush = fl;
    rsd   = rs;
    rtd   = rt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_stall(output int cnt);
    cnt = 0;
    while (stall === 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy === 1'b1 && k < 200) begin
      tick();
      k++;
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    drive(MD_MFHI, 1'b0, 32'd0, 32'd0);
    #1;
    chk({tag, "_hi"}, mdout, hi);
    drive(MD_MFLO, 1'b0, 32'd0, 32'd0);
    #1;
    chk({tag, "_lo"}, mdout, lo);
    drive(MD_NONE, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic run_op(input string tag, input md_op_t op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] hi, input logic [31:0] lo);
    drive(op, 1'b0, rs, rt);
    tick();
    drive(MD_NONE, 1'b0, 32'd0, 32'd0);
    wait_idle(tag);
    read_hilo(tag, hi, lo);
  endtask

  initial begin
    nrst = 1'b0;
    drive(MD_NONE, 1'b0, 32'd0, 32'd0);
    tick();
    tick();
    nrst = 1'b1;

    // Reset state
    drive(MD_MFHI, 1'b0, 32'd0, 32'd0);
    #1;
    chk("rst_mdout", mdout, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // MTLO while idle
    drive(MD_MTLO, 1'b0, 32'h0000_1234, 32'd0);
    tick();
    drive(MD_MFLO, 1'b0, 32'd0, 32'd0);
    #1;
    chk("mtlo", mdout, 32'h0000_1234);
    chk("mtlo_stall", {31'd0, stall}, 32'd0);

    // MULT -3 * 7 followed by a dependent MFLO
    drive(MD_MULT, 1'b0, 32'hFFFF_FFFD, 32'd7);
    tick();
    chk("mult_busy", {31'd0, busy}, MUL_BUSY);
    drive(MD_MFLO, 1'b0, 32'd0, 32'd0);
    #1;
    count_stall(n);
    chk("mult_stall_cycles", n, MUL_STALL);
    chk("mult_lo", mdout, 32'hFFFF_FFEB);
    drive(MD_MFHI, 1'b0, 32'd0, 32'd0);
    #1;
    chk("mult_hi", mdout, 32'hFFFF_FFFF);
    drive(MD_NONE, 1'b0, 32'd0, 32'd0);

    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_zero", MD_DIVU, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF);
    run_op("div_zero_neg", MD_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    // Flushed MFHI behind a MULT neither stalls nor disturbs the MULT
    drive(MD_MULT, 1'b0, 32'h0001_0000, 32'h0001_0000);
    tick();
    drive(MD_MFHI, 1'b1, 32'd0, 32'd0);
    #1;
    chk("flush_stall", {31'd0, stall}, 32'd0);
    tick();
    drive(MD_NONE, 1'b0, 32'd0, 32'd0);
    wait_idle("flush");
    read_hilo("flush_mult", 32'h0000_0001, 32'h0000_0000);

    // MTHI presented during DIVU waits until the result is written
    drive(MD_DIVU, 1'b0, 32'd100, 32'd7);
    tick();
    drive(MD_MTHI, 1'b0, 32'h0000_ABCD, 32'd0);
    #1;
    count_stall(n);
    chk("mthi_stall_cycles", n, 33);
    tick();
    read_hilo("mthi_after_div", 32'h0000_ABCD, 32'h0000_000E);

    // DIVU presented in FIX stalls once, then issues
    drive(MD_DIVU, 1'b0, 32'd9, 32'd3);
    tick();
    drive(MD_NONE, 1'b0, 32'd0, 32'd0);
    repeat (32) tick();
    chk("fix_busy", {31'd0, busy}, 32'd1);
    drive(MD_DIVU, 1'b0, 32'd20, 32'd6);
    #1;
    count_stall(n);
    chk("fix_stall_cycles", n, 1);
    tick();
    drive(MD_NONE, 1'b0, 32'd0, 32'd0);
    wait_idle("b2b");
    read_hilo("b2b_div", 32'h0000_0002, 32'h0000_0003);

    // Reset in the middle of a DIV
    drive(MD_DIV, 1'b0, 32'hFFFF_FF9C, 32'd7);
    tick();
    drive(MD_NONE, 1'b0, 32'd0, 32'd0);
    repeat (3) tick();
    chk("middiv_busy", {31'd0, busy}, 32'd1);
    nrst = 1'b0;
    drive(MD_MFHI, 1'b0, 32'd0, 32'd0);
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_hi", mdout, 32'd0);
    drive(MD_MFLO, 1'b0, 32'd0, 32'd0);
    #1;
    chk("midrst_lo", mdout, 32'd0);
    tick();
    nrst = 1'b1;
    tick();
    chk("postrst_lo", mdout, 32'd0);
    chk("postrst_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
